// File: rtl/bb_pkg.sv
// Shared types for the baseball scorekeeper: play codes, result codes,
// FSM state encoding and a runner-count helper.
package bb_pkg;

    typedef enum logic [2:0] {
        ACT_WALK   = 3'd0,
        ACT_SINGLE = 3'd1,
        ACT_DOUBLE = 3'd2,
        ACT_TRIPLE = 3'd3,
        ACT_HR     = 3'd4,
        ACT_BUNT   = 3'd5,
        ACT_GROUND = 3'd6,
        ACT_FLY    = 3'd7
    } action_e;

    localparam logic [1:0] A_WIN = 2'd0;
    localparam logic [1:0] B_WIN = 2'd1;
    localparam logic [1:0] DRAW  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // bases[0] = 1st, bases[1] = 2nd, bases[2] = 3rd
    function automatic logic [2:0] count_runners(input logic [2:0] b);
        return 3'(b[0]) + 3'(b[1]) + 3'(b[2]);
    endfunction

endpackage

// File: rtl/bb_play_resolver.sv
// Combinational resolution of one play: given outs and occupied bases before
// the play, produce outs, bases and runs after it, plus the half-ending flag.
module bb_play_resolver
    import bb_pkg::*;
#(
    parameter int OUTS_PER_HALF = 3
)(
    input  logic [1:0] outs,
    input  logic [2:0] bases,
    input  action_e    action,
    output logic [1:0] next_outs,
    output logic [2:0] next_bases,
    output logic [2:0] runs,
    output logic       half_end
);

    logic       two_out;
    logic [1:0] outs_added;
    logic [2:0] outs_total;
    logic [2:0] adv_bases;
    logic [2:0] adv_runs;

    assign two_out    = (outs == 2'(OUTS_PER_HALF - 1));
    assign outs_total = 3'(outs) + 3'(outs_added);

    always_comb begin
        outs_added = 2'd0;
        adv_bases  = bases;
        adv_runs   = 3'd0;
        case (action)
            ACT_WALK: begin
                adv_bases = {bases[2] | (bases[1] & bases[0]), bases[1] | bases[0], 1'b1};
                adv_runs  = {2'b00, &bases};
            end
            ACT_SINGLE: begin
                if (two_out) begin
                    adv_bases = {bases[0], 1'b0, 1'b1};
                    adv_runs  = 3'(bases[1]) + 3'(bases[2]);
                end else begin
                    adv_bases = {bases[1], bases[0], 1'b1};
                    adv_runs  = 3'(bases[2]);
                end
            end
            ACT_DOUBLE: begin
                if (two_out) begin
                    adv_bases = 3'b010;
                    adv_runs  = count_runners(bases);
                end else begin
                    adv_bases = {bases[0], 1'b1, 1'b0};
                    adv_runs  = 3'(bases[1]) + 3'(bases[2]);
                end
            end
            ACT_TRIPLE: begin
                adv_bases = 3'b100;
                adv_runs  = count_runners(bases);
            end
            ACT_HR: begin
                adv_bases = 3'b000;
                adv_runs  = count_runners(bases) + 3'd1;
            end
            ACT_BUNT: begin
                outs_added = 2'd1;
                adv_bases  = {bases[1], bases[0], 1'b0};
                adv_runs   = 3'(bases[2]);
            end
            ACT_GROUND: begin
                // runner forced out at 2nd when 1st is occupied
                outs_added = bases[0] ? 2'd2 : 2'd1;
                adv_bases  = {bases[1], 2'b00};
                adv_runs   = 3'(bases[2]);
            end
            ACT_FLY: begin
                outs_added = 2'd1;
                adv_bases  = {1'b0, bases[1], bases[0]};
                adv_runs   = 3'(bases[2]);
            end
            default: begin
                adv_bases = bases;
            end
        endcase
    end

    // Only out plays can close a half; the closing play scores nothing.
    always_comb begin
        half_end = (outs_added != 2'd0) && (outs_total >= 3'(OUTS_PER_HALF));
        if (half_end) begin
            next_outs  = 2'd0;
            next_bases = 3'b000;
            runs       = 3'd0;
        end else begin
            next_outs  = outs_total[1:0];
            next_bases = adv_bases;
            runs       = adv_runs;
        end
    end

endmodule

// File: rtl/bb_scorekeeper.sv
// Whole-game baseball engine: applies one play per valid beat, keeps
// saturating per-team scores and pulses the final result after the stream.
module bb_scorekeeper
    import bb_pkg::*;
#(
    parameter  int INNINGS       = 3,
    parameter  int OUTS_PER_HALF = 3,
    parameter  int SCORE_W       = 8,
    localparam int IW            = $clog2(INNINGS + 1)
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [IW-1:0]      inning,
    input  logic               half,
    input  logic [2:0]         action,
    output logic               out_valid,
    output logic [SCORE_W-1:0] score_A,
    output logic [SCORE_W-1:0] score_B,
    output logic [1:0]         result
);

    state_e             state_reg, state_next;
    logic [1:0]         outs_reg, outs_next;
    logic [2:0]         bases_reg, bases_next;
    logic [IW-1:0]      last_inning_reg, last_inning_next;
    logic               last_half_reg, last_half_next;
    logic [SCORE_W-1:0] score_reg  [2];
    logic [SCORE_W-1:0] score_next [2];
    logic [SCORE_W-1:0] base_score [2];

    logic       new_game;
    logic       apply;
    logic       half_change;
    logic [1:0] cur_outs;
    logic [2:0] cur_bases;
    logic       walkoff_gate;
    logic [2:0] credit_runs;

    logic [1:0] res_outs;
    logic [2:0] res_bases;
    logic [2:0] res_runs;
    logic       res_half_end;

    assign new_game = (state_reg == ST_IDLE) && in_valid;
    assign apply    = in_valid && (state_reg != ST_DONE);

    // The first beat of a game always counts as a fresh half.
    assign half_change = new_game || (inning != last_inning_reg) || (half != last_half_reg);
    assign cur_outs    = half_change ? 2'd0 : outs_reg;
    assign cur_bases   = half_change ? 3'b000 : bases_reg;

    bb_play_resolver #(
        .OUTS_PER_HALF(OUTS_PER_HALF)
    ) u_resolver (
        .outs       (cur_outs),
        .bases      (cur_bases),
        .action     (action_e'(action)),
        .next_outs  (res_outs),
        .next_bases (res_bases),
        .runs       (res_runs),
        .half_end   (res_half_end)
    );

    // Home team already ahead in the last bottom half: nothing more counts.
    assign walkoff_gate = (inning == IW'(INNINGS)) && half && (base_score[1] > base_score[0]);
    assign credit_runs  = (walkoff_gate || res_half_end) ? 3'd0 : res_runs;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_team
            logic               team_bats;
            logic [2:0]         team_runs;
            logic [SCORE_W:0]   sum;
            logic [SCORE_W-1:0] sat_score;

            assign base_score[gi] = new_game ? '0 : score_reg[gi];
            assign team_bats      = (half == 1'(gi));
            assign team_runs      = team_bats ? credit_runs : 3'd0;
            assign sum            = {1'b0, base_score[gi]} + {{(SCORE_W-2){1'b0}}, team_runs};
            assign sat_score      = sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
            assign score_next[gi] = apply ? sat_score : score_reg[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    score_reg[gi] <= '0;
                end else begin
                    score_reg[gi] <= score_next[gi];
                end
            end
        end
    endgenerate

    always_comb begin
        state_next       = state_reg;
        outs_next        = outs_reg;
        bases_next       = bases_reg;
        last_inning_next = last_inning_reg;
        last_half_next   = last_half_reg;
        case (state_reg)
            ST_IDLE: if (in_valid)  state_next = ST_PLAY;
            ST_PLAY: if (!in_valid) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (apply) begin
            outs_next        = res_outs;
            bases_next       = res_bases;
            last_inning_next = inning;
            last_half_next   = half;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            outs_reg        <= 2'd0;
            bases_reg       <= 3'b000;
            last_inning_reg <= '0;
            last_half_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            outs_reg        <= outs_next;
            bases_reg       <= bases_next;
            last_inning_reg <= last_inning_next;
            last_half_reg   <= last_half_next;
        end
    end

    assign out_valid = (state_reg == ST_DONE);
    assign score_A   = out_valid ? score_reg[0] : '0;
    assign score_B   = out_valid ? score_reg[1] : '0;

    always_comb begin
        result = A_WIN;
        if (out_valid) begin
            if (score_reg[0] > score_reg[1])      result = A_WIN;
            else if (score_reg[1] > score_reg[0]) result = B_WIN;
            else                                  result = DRAW;
        end
    end

endmodule

// File: tb/tb_bb_scorekeeper.sv
// Directed bench for bb_scorekeeper: a one-inning/4-bit instance and a
// two-inning/8-bit instance share the play stream; each test checks one.
module tb_bb_scorekeeper;
    import bb_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] inn_drv = 4'd1;
    logic       half = 1'b0;
    logic [2:0] action = 3'd0;

    logic       one_valid, two_valid;
    logic [3:0] one_a, one_b;
    logic [7:0] two_a, two_b;
    logic [1:0] one_res, two_res;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bb_scorekeeper #(.INNINGS(1), .OUTS_PER_HALF(3), .SCORE_W(4)) u_one (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .inning(inn_drv[0:0]),
        .half(half), .action(action), .out_valid(one_valid),
        .score_A(one_a), .score_B(one_b), .result(one_res)
    );

    bb_scorekeeper #(.INNINGS(2), .OUTS_PER_HALF(3), .SCORE_W(8)) u_two (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .inning(inn_drv[1:0]),
        .half(half), .action(action), .out_valid(two_valid),
        .score_A(two_a), .score_B(two_b), .result(two_res)
    );

    task automatic beat(input int inn, input bit h, input logic [2:0] act);
        in_valid = 1'b1;
        inn_drv  = 4'(inn);
        half     = h;
        action   = act;
        @(posedge clk); #1;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++; if (two_valid !== 1'b0) begin miscompares++; $display("FAIL reset out_valid: got %0d expected 0", two_valid); end
        vectors++; if (two_a !== 8'd0 || two_b !== 8'd0) begin miscompares++; $display("FAIL reset scores: got %0d/%0d expected 0/0", two_a, two_b); end
        vectors++; if (two_res !== 2'd0) begin miscompares++; $display("FAIL reset result: got %0d expected 0", two_res); end
        vectors++; if (one_valid !== 1'b0 || one_a !== 4'd0) begin miscompares++; $display("FAIL reset one: got valid %0d A %0d expected 0 0", one_valid, one_a); end
        rst_n = 1'b1;
        idle_cycle();
        vectors++; if (two_valid !== 1'b0) begin miscompares++; $display("FAIL reset idle out_valid: got %0d expected 0", two_valid); end
    endtask

    task automatic test_basic_game();
        beat(1, 0, ACT_HR);
        beat(1, 1, ACT_FLY);
        beat(1, 1, ACT_FLY);
        beat(1, 1, ACT_FLY);
        vectors++; if (one_valid !== 1'b0) begin miscompares++; $display("FAIL basic early out_valid: got %0d expected 0", one_valid); end
        idle_cycle();
        vectors++; if (one_valid !== 1'b1) begin miscompares++; $display("FAIL basic out_valid: got %0d expected 1", one_valid); end
        vectors++; if (one_a !== 4'd1 || one_b !== 4'd0) begin miscompares++; $display("FAIL basic scores: got %0d/%0d expected 1/0", one_a, one_b); end
        vectors++; if (one_res !== A_WIN) begin miscompares++; $display("FAIL basic result: got %0d expected %0d", one_res, A_WIN); end
        idle_cycle();
        vectors++; if (one_valid !== 1'b0 || one_a !== 4'd0) begin miscompares++; $display("FAIL basic pulse end: got valid %0d A %0d expected 0 0", one_valid, one_a); end
    endtask

    task automatic test_walk_and_ground();
        beat(1, 0, ACT_SINGLE);
        beat(1, 0, ACT_SINGLE);
        beat(1, 0, ACT_SINGLE);
        beat(1, 0, ACT_WALK);
        beat(1, 0, ACT_WALK);
        beat(1, 0, ACT_BUNT);
        beat(1, 0, ACT_WALK);
        beat(1, 0, ACT_GROUND);
        beat(1, 1, ACT_HR);
        idle_cycle();
        vectors++; if (two_a !== 8'd3) begin miscompares++; $display("FAIL walk_ground score_A: got %0d expected 3", two_a); end
        vectors++; if (two_b !== 8'd1) begin miscompares++; $display("FAIL walk_ground score_B: got %0d expected 1", two_b); end
        vectors++; if (two_res !== A_WIN) begin miscompares++; $display("FAIL walk_ground result: got %0d expected %0d", two_res, A_WIN); end
        idle_cycle();
    endtask

    task automatic test_two_out_hits();
        beat(1, 0, ACT_FLY);
        beat(1, 0, ACT_WALK);
        beat(1, 0, ACT_WALK);
        beat(1, 0, ACT_BUNT);
        beat(1, 0, ACT_SINGLE);
        idle_cycle();
        vectors++; if (two_a !== 8'd2) begin miscompares++; $display("FAIL two_out_single score_A: got %0d expected 2", two_a); end
        idle_cycle();
        beat(1, 0, ACT_FLY);
        beat(1, 0, ACT_FLY);
        beat(1, 0, ACT_WALK);
        beat(1, 0, ACT_WALK);
        beat(1, 0, ACT_WALK);
        beat(1, 0, ACT_DOUBLE);
        idle_cycle();
        vectors++; if (two_a !== 8'd3) begin miscompares++; $display("FAIL two_out_double score_A: got %0d expected 3", two_a); end
        idle_cycle();
    endtask

    task automatic test_draw();
        beat(1, 0, ACT_HR);
        beat(1, 1, ACT_HR);
        idle_cycle();
        vectors++; if (two_a !== 8'd1 || two_b !== 8'd1) begin miscompares++; $display("FAIL draw scores: got %0d/%0d expected 1/1", two_a, two_b); end
        vectors++; if (two_res !== DRAW) begin miscompares++; $display("FAIL draw result: got %0d expected %0d", two_res, DRAW); end
        idle_cycle();
    endtask

    task automatic test_skipped_bottom();
        beat(1, 0, ACT_HR);
        beat(1, 1, ACT_HR);
        beat(1, 1, ACT_HR);
        beat(2, 0, ACT_FLY);
        beat(2, 1, ACT_HR);
        beat(2, 1, ACT_SINGLE);
        idle_cycle();
        vectors++; if (two_a !== 8'd1 || two_b !== 8'd2) begin miscompares++; $display("FAIL skipped_bottom scores: got %0d/%0d expected 1/2", two_a, two_b); end
        vectors++; if (two_res !== B_WIN) begin miscompares++; $display("FAIL skipped_bottom result: got %0d expected %0d", two_res, B_WIN); end
        idle_cycle();
    endtask

    task automatic test_walk_off();
        beat(1, 0, ACT_FLY);
        beat(1, 1, ACT_FLY);
        beat(2, 0, ACT_FLY);
        beat(2, 1, ACT_TRIPLE);
        beat(2, 1, ACT_SINGLE);
        beat(2, 1, ACT_HR);
        idle_cycle();
        vectors++; if (two_a !== 8'd0 || two_b !== 8'd1) begin miscompares++; $display("FAIL walk_off scores: got %0d/%0d expected 0/1", two_a, two_b); end
        vectors++; if (two_res !== B_WIN) begin miscompares++; $display("FAIL walk_off result: got %0d expected %0d", two_res, B_WIN); end
        idle_cycle();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) begin
            beat(1, 0, ACT_WALK);
            beat(1, 0, ACT_WALK);
            beat(1, 0, ACT_WALK);
            beat(1, 0, ACT_HR);
        end
        idle_cycle();
        vectors++; if (one_a !== 4'd15) begin miscompares++; $display("FAIL saturation score_A: got %0d expected 15", one_a); end
        vectors++; if (one_res !== A_WIN) begin miscompares++; $display("FAIL saturation result: got %0d expected %0d", one_res, A_WIN); end
        vectors++; if (two_a !== 8'd20) begin miscompares++; $display("FAIL wide score_A: got %0d expected 20", two_a); end
        idle_cycle();
    endtask

    task automatic test_reset_mid_game();
        int pulses;
        pulses = 0;
        beat(1, 0, ACT_HR);
        beat(1, 0, ACT_HR);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            if (two_valid !== 1'b0) pulses++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (two_valid !== 1'b0) pulses++;
        end
        vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL reset_mid out_valid pulses: got %0d expected 0", pulses); end
        beat(1, 0, ACT_HR);
        idle_cycle();
        vectors++; if (two_valid !== 1'b1) begin miscompares++; $display("FAIL reset_mid next out_valid: got %0d expected 1", two_valid); end
        vectors++; if (two_a !== 8'd1) begin miscompares++; $display("FAIL reset_mid next score_A: got %0d expected 1", two_a); end
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        beat(1, 0, ACT_HR);
        idle_cycle();
        vectors++; if (two_valid !== 1'b1 || two_a !== 8'd1) begin miscompares++; $display("FAIL single_beat: got valid %0d A %0d expected 1 1", two_valid, two_a); end
        beat(1, 0, ACT_HR);
        vectors++; if (two_valid !== 1'b0) begin miscompares++; $display("FAIL done_drop out_valid: got %0d expected 0", two_valid); end
        beat(1, 0, ACT_HR);
        beat(1, 0, ACT_HR);
        idle_cycle();
        vectors++; if (two_valid !== 1'b1 || two_a !== 8'd2) begin miscompares++; $display("FAIL back_to_back: got valid %0d A %0d expected 1 2", two_valid, two_a); end
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_basic_game();
        test_walk_and_ground();
        test_two_out_hits();
        test_draw();
        test_skipped_bottom();
        test_walk_off();
        test_saturation();
        test_reset_mid_game();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
